exc_ctrl: RTL and testbench

- Exception sequencer that sits directly upstream of the CP0 register file in the 54-instruction multi-cycle CPU.
- Takes decoded syscall/break/teq/eret flags, the external interrupt line, and CP0 status/epc.
- Produces CP0 `exception`/`cause`/`pc`/`eret` strobes, the status push/pop write, the PC redirect, and the pipeline stall.
- Runs on posedge clk; CP0 samples its outputs on the following negedge.

---
 rtl/exc_pkg.sv | 26 ++
 rtl/exc_ctrl_int_sync.sv | 32 +++
 rtl/exc_ctrl.sv | 124 ++++++++++++
 tb/tb_exc_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared constants for the exception sequencer: cause codes, CP0 status bit
// positions and the sequencer state encoding.
package exc_pkg;

   localparam logic [4:0] CAUSE_INT     = 5'b00000;
   localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
   localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
   localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

   localparam int IE_BIT         = 0;
   localparam int SYSCALL_EN_BIT = 8;
   localparam int BREAK_EN_BIT   = 9;
   localparam int TEQ_EN_BIT     = 10;
   localparam int INT_EN_BIT     = 11;

   // CP0 register number of status, used by the mtc0 write mux downstream.
   localparam logic [4:0] STATUS_INDEX = 5'd12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TAKE   = 2'd1,
      VECTOR = 2'd2,
      ERET   = 2'd3
   } state_t;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchronizer for the external interrupt line, rising-edge detect,
// and the pending latch that holds one request until it is taken.
module int_sync (
   input  logic clk,
   input  logic rst,
   input  logic ext_int,
   input  logic clr,
   output logic pend
);

   // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
   logic [2:0] sync_q;
   logic       rise;

   assign rise = sync_q[1] & ~sync_q[2];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         pend   <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], ext_int};
         // A fresh edge wins over a same-cycle clear so no request is lost.
         if (rise)
            pend <= 1'b1;
         else if (clr)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer feeding the CP0 register file: decides trap/eret on each
// decoded instruction and walks the TAKE -> VECTOR or ERET strobe sequence.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
   parameter int          SHIFT      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic        is_syscall,
   input  logic        is_break,
   input  logic        is_teq,
   input  logic        teq_eq,
   input  logic        is_eret,
   input  logic [31:0] cur_pc,
   input  logic [31:0] status,
   input  logic [31:0] epc,
   input  logic        ext_int,
   output logic        exception,
   output logic [4:0]  cause,
   output logic [31:0] exc_pc,
   output logic        eret_out,
   output logic        status_we,
   output logic [31:0] status_wdata,
   output logic        pc_redirect,
   output logic [31:0] redirect_target,
   output logic        stall,
   output logic        squash
);

   state_t     state;
   logic       int_pend;
   logic       brk_trap, sys_trap, teq_trap, int_trap;
   logic       idle, go_eret, go_trap, int_taken;
   logic [4:0] trap_code;

   int_sync u_int_sync (
      .clk     (clk),
      .rst     (rst),
      .ext_int (ext_int),
      .clr     (int_taken),
      .pend    (int_pend)
   );

   assign idle     = (state == IDLE);
   assign brk_trap = is_break   & status[IE_BIT] & status[BREAK_EN_BIT];
   assign sys_trap = is_syscall & status[IE_BIT] & status[SYSCALL_EN_BIT];
   assign teq_trap = is_teq & teq_eq & status[IE_BIT] & status[TEQ_EN_BIT];
   assign int_trap = int_pend   & status[IE_BIT] & status[INT_EN_BIT];

   // eret outranks everything, including a pending interrupt, which stays pending.
   assign go_eret   = idle & instr_valid & is_eret;
   assign go_trap   = idle & instr_valid & ~is_eret
                    & (brk_trap | sys_trap | teq_trap | int_trap);
   assign int_taken = go_trap & ~brk_trap & ~sys_trap & ~teq_trap;

   // NOTE: combinational blocks assign a default first so no latch is inferred.
   always_comb begin
      trap_code = CAUSE_INT;
      if (brk_trap)
         trap_code = CAUSE_BREAK;
      else if (sys_trap)
         trap_code = CAUSE_SYSCALL;
      else if (teq_trap)
         trap_code = CAUSE_TEQ;
   end

   // Squash and the first stall cycle must act on the decoding instruction itself.
   assign stall  = ~rst & (~idle | go_eret | go_trap);
   assign squash = ~rst & go_trap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         exception       <= 1'b0;
         cause           <= '0;
         exc_pc          <= '0;
         eret_out        <= 1'b0;
         status_we       <= 1'b0;
         status_wdata    <= '0;
         pc_redirect     <= 1'b0;
         redirect_target <= '0;
      end else begin
         // Every strobe and its data are single-cycle; they drop unless re-set below.
         exception       <= 1'b0;
         cause           <= '0;
         exc_pc          <= '0;
         eret_out        <= 1'b0;
         status_we       <= 1'b0;
         status_wdata    <= '0;
         pc_redirect     <= 1'b0;
         redirect_target <= '0;
         case (state)
            IDLE: begin
               if (go_eret) begin
                  state           <= ERET;
                  eret_out        <= 1'b1;
                  status_we       <= 1'b1;
                  status_wdata    <= status >> SHIFT;
                  pc_redirect     <= 1'b1;
                  redirect_target <= epc;
               end else if (go_trap) begin
                  state        <= TAKE;
                  exception    <= 1'b1;
                  cause        <= trap_code;
                  exc_pc       <= cur_pc;
                  status_we    <= 1'b1;
                  status_wdata <= status << SHIFT;
               end
            end
            TAKE: begin
               state           <= VECTOR;
               pc_redirect     <= 1'b1;
               redirect_target <= EXC_VECTOR;
            end
            VECTOR: state <= IDLE;
            ERET:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized
// instructions compared against a rule-level model of the trap sequencer.
module tb_exc_ctrl;

   localparam logic [31:0] VEC = 32'h0040_0004;

   typedef logic [106:0] obs_t;
   typedef enum int {K_NONE, K_TRAP, K_ERET} kind_t;

   logic        clk = 1'b0;
   logic        rst, instr_valid, is_syscall, is_break, is_teq, teq_eq, is_eret, ext_int;
   logic [31:0] cur_pc, status, epc;
   logic        exception, eret_out, status_we, pc_redirect, stall, squash;
   logic [4:0]  cause;
   logic [31:0] exc_pc, status_wdata, redirect_target;

   int n_cmp = 0;
   int n_bad = 0;
   bit model_pend = 1'b0;

   always #5 clk = ~clk;

   exc_ctrl #(.EXC_VECTOR(VEC), .SHIFT(5)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_syscall(is_syscall),
      .is_break(is_break), .is_teq(is_teq), .teq_eq(teq_eq), .is_eret(is_eret),
      .cur_pc(cur_pc), .status(status), .epc(epc), .ext_int(ext_int),
      .exception(exception), .cause(cause), .exc_pc(exc_pc), .eret_out(eret_out),
      .status_we(status_we), .status_wdata(status_wdata), .pc_redirect(pc_redirect),
      .redirect_target(redirect_target), .stall(stall), .squash(squash)
   );

   function automatic obs_t snap();
      return {exception, cause, exc_pc, eret_out, status_we, status_wdata,
              pc_redirect, redirect_target, stall, squash};
   endfunction

   function automatic obs_t pack(logic ex, logic [4:0] c, logic [31:0] pc, logic er, logic we,
                                 logic [31:0] wd, logic rd, logic [31:0] tg, logic st, logic sq);
      return {ex, c, pc, er, we, wd, rd, tg, st, sq};
   endfunction

   // Expected outputs, phase 0 = decode cycle, phase n = n cycles later.
   function automatic obs_t expect_phase(kind_t k, logic [4:0] code, logic [31:0] pc,
                                         logic [31:0] st, logic [31:0] ep, int ph);
      obs_t e = '0;
      if (k == K_TRAP) begin
         if (ph == 0) e = pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
         if (ph == 1) e = pack(1, code, pc, 0, 1, st << 5, 0, 0, 1, 0);
         if (ph == 2) e = pack(0, 0, 0, 0, 0, 0, 1, VEC, 1, 0);
      end else if (k == K_ERET) begin
         if (ph == 0) e = pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         if (ph == 1) e = pack(0, 0, 0, 1, 1, st >> 5, 1, ep, 1, 0);
      end
      return e;
   endfunction

   // Rule-level decision: eret, else enabled trap by priority, else pending interrupt.
   task automatic classify(input bit sc, bk, tq, tqe, er, input logic [31:0] st,
                           output kind_t k, output logic [4:0] code);
      k = K_NONE;
      code = 5'd0;
      if (er) k = K_ERET;
      else if (st[0]) begin
         if (bk && st[9])             begin k = K_TRAP; code = 5'd9;  end
         else if (sc && st[8])        begin k = K_TRAP; code = 5'd8;  end
         else if (tq && tqe && st[10]) begin k = K_TRAP; code = 5'd13; end
         else if (model_pend && st[11]) begin k = K_TRAP; code = 5'd0; model_pend = 0; end
      end
   endtask

   task automatic clear_inputs();
      instr_valid = 0; is_syscall = 0; is_break = 0; is_teq = 0; teq_eq = 0; is_eret = 0;
   endtask

   // Issue one decoded instruction (called just after a posedge) and check 4 cycles.
   task automatic run_instr(input string name, input bit sc, bk, tq, tqe, er,
                            input logic [31:0] pc, st, ep);
      kind_t k;
      logic [4:0] code;
      obs_t got, exp;
      classify(sc, bk, tq, tqe, er, st, k, code);
      is_syscall = sc; is_break = bk; is_teq = tq; teq_eq = tqe; is_eret = er;
      cur_pc = pc; status = st; epc = ep; instr_valid = 1;
      for (int ph = 0; ph < 4; ph++) begin
         if (ph == 0) #1;
         else begin
            @(posedge clk); #1;
            clear_inputs();
            #1;
         end
         got = snap();
         exp = expect_phase(k, code, pc, st, ep, ph);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL %s ph%0d: got %h want %h", name, ph, got, exp);
         end
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_int(input int hold);
      ext_int = 1;
      wait_cycles(hold);
      ext_int = 0;
      wait_cycles(4);
      model_pend = 1;
   endtask

   task automatic test_reset();
      rst = 1; ext_int = 0; cur_pc = 0; status = 0; epc = 0;
      clear_inputs();
      wait_cycles(2);
      n_cmp++;
      if (snap() !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got %h want 0", snap());
      end
      rst = 0;
      wait_cycles(1);
   endtask

   task automatic test_syscall();
      run_instr("syscall", 1, 0, 0, 0, 0, 32'h0040_0100, 32'h0000_0701, 32'h0);
      run_instr("break",   0, 1, 0, 0, 0, 32'h0040_0108, 32'h0000_0701, 32'h0);
      run_instr("syscall_ie0", 1, 0, 0, 0, 0, 32'h0040_0110, 32'h0000_0700, 32'h0);
   endtask

   task automatic test_teq();
      run_instr("teq_ne",  0, 0, 1, 0, 0, 32'h0040_0120, 32'h0000_0701, 32'h0);
      run_instr("teq_eq",  0, 0, 1, 1, 0, 32'h0040_0124, 32'h0000_0701, 32'h0);
      run_instr("teq_dis", 0, 0, 1, 1, 0, 32'h0040_0128, 32'h0000_0301, 32'h0);
   endtask

   task automatic test_eret();
      run_instr("eret", 0, 0, 0, 0, 1, 32'h0040_0300, 32'h0000_E020, 32'h0040_0104);
   endtask

   task automatic test_interrupt();
      // Decode 2 cycles after the edge is too early: pending appears on the third.
      ext_int = 1;
      wait_cycles(2);
      run_instr("int_early", 0, 0, 0, 0, 0, 32'h0040_01F0, 32'h0000_0F01, 32'h0);
      ext_int = 0;
      model_pend = 1;
      run_instr("int_take",  0, 0, 0, 0, 0, 32'h0040_0200, 32'h0000_0F01, 32'h0);
      run_instr("int_clear", 0, 0, 0, 0, 0, 32'h0040_0204, 32'h0000_0F01, 32'h0);
      pulse_int(2);
      run_instr("int_ie0",   0, 0, 0, 0, 0, 32'h0040_0208, 32'h0000_0F00, 32'h0);
      run_instr("int_prio",  1, 0, 0, 0, 0, 32'h0040_020C, 32'h0000_0F01, 32'h0);
      run_instr("int_late",  0, 0, 0, 0, 0, 32'h0040_0210, 32'h0000_0F01, 32'h0);
      pulse_int(1);
      pulse_int(1);
      run_instr("int_multi", 0, 0, 0, 0, 0, 32'h0040_0214, 32'h0000_0F01, 32'h0);
      run_instr("int_once",  0, 0, 0, 0, 0, 32'h0040_0218, 32'h0000_0F01, 32'h0);
   endtask

   task automatic test_eret_vs_int();
      pulse_int(2);
      run_instr("sim_eret", 0, 0, 0, 0, 1, 32'h0040_0400, 32'h0001_E020, 32'h0040_0104);
      run_instr("sim_int",  0, 0, 0, 0, 0, 32'h0040_0104, 32'h0000_0F01, 32'h0);
   endtask

   task automatic test_reset_mid();
      pulse_int(2);
      is_syscall = 1; cur_pc = 32'h0040_0500; status = 32'h0000_0701; instr_valid = 1;
      @(posedge clk); #1;
      clear_inputs();
      #1;
      n_cmp++;
      if (exception !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_take: exception got %b want 1", exception);
      end
      rst = 1;
      #1;
      n_cmp++;
      if (snap() !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_now: got %h want 0", snap());
      end
      wait_cycles(1);
      rst = 0;
      model_pend = 0;
      for (int i = 0; i < 3; i++) begin
         wait_cycles(1);
         n_cmp++;
         if (snap() !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_after%0d: got %h want 0", i, snap());
         end
      end
      run_instr("rst_pend_gone", 0, 0, 0, 0, 0, 32'h0040_0504, 32'h0000_0F01, 32'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int pick;
         logic [31:0] st;
         pick = $urandom_range(0, 4);
         st = $urandom;
         st[0] = ($urandom_range(0, 3) != 0);
         run_instr("random", pick == 1, pick == 2, pick == 3, $urandom_range(0, 1) == 1,
                   pick == 4, $urandom, st, $urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_syscall();
      test_teq();
      test_eret();
      test_interrupt();
      test_eret_vs_int();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
